// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
//
// Two-master round-robin arbiter and sequencer placed in front of the
// single-port data_memory. Master 0 is the core load/store unit and master 1
// is the DMA/debug loader. Each request is range- and alignment-checked
// against the memory window, then run as a fixed three-cycle transaction
// (IDLE -> ACCESS -> RESP). Completion is signalled with a one-cycle ack.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active high
//   mN_req_i     request from master N, held until its ack
//   mN_we_i      1 = write, 0 = read
//   mN_addr_i    byte address
//   mN_wd_i      write data
//   mN_ack_o     one-cycle completion pulse
//   mN_err_o     qualified by mN_ack_o: address out of window or misaligned
//   mN_rd_o      read data, valid with the ack and held until the next ack
//   mem_addr_o   address to data_memory
//   mem_wd_o     write data to data_memory
//   mem_we_o     write enable to data_memory (commits on the ACCESS closing edge)
//   mem_rd_i     combinational read data from data_memory
// ---------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h6600_0000,
    parameter int unsigned       DEPTH_WORDS = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wd_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rd_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wd_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rd_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rd_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The upper bound is kept one bit wider than the address so that a window
    // ending exactly at 2^ADDR_W cannot wrap around to zero.
    localparam logic [ADDR_W:0] WINDOW_BYTES = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    localparam logic [ADDR_W:0] WINDOW_END   = {1'b0, BASE_ADDR} + WINDOW_BYTES;

    logic [1:0]        state;
    logic              last;
    logic              sel_q;
    logic              we_q;
    logic              legal_q;

    logic              any_req;
    logic              grant_sel;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wd;
    logic              grant_legal;
    logic [DATA_W-1:0] access_rd;

    // Word-aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] wide;
        wide = {1'b0, a};
        return (a >= BASE_ADDR) && (wide < WINDOW_END) && (a[1:0] == 2'b00);
    endfunction

    // Grant selection. With a single requester it simply wins; with both,
    // the master that was not served last wins, which gives strict
    // alternation under continuous contention.
    always_comb begin
        any_req   = m0_req_i | m1_req_i;
        grant_sel = 1'b0;
        if (m0_req_i && m1_req_i) begin
            grant_sel = ~last;
        end else if (m1_req_i) begin
            grant_sel = 1'b1;
        end

        grant_we    = grant_sel ? m1_we_i   : m0_we_i;
        grant_addr  = grant_sel ? m1_addr_i : m0_addr_i;
        grant_wd    = grant_sel ? m1_wd_i   : m0_wd_i;
        grant_legal = addr_legal(grant_addr);
    end

    // Data returned at the end of ACCESS: only a legal read passes memory
    // data through; writes and rejected accesses return zero.
    always_comb begin
        access_rd = '0;
        if (legal_q && !we_q) begin
            access_rd = mem_rd_i;
        end
    end

    // Sequencer FSM plus the round-robin pointer. The pointer starts at 1 so
    // that master 0 wins the first tie after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    last  <= sel_q;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request capture and memory drive. The memory address/data registers
    // double as the latched request, so the memory side only ever changes on
    // a clock edge or reset and holds its last value in IDLE and RESP.
    // The write enable is high for exactly the ACCESS cycle of a legal write;
    // the asynchronous reset drops it immediately, aborting the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            legal_q    <= 1'b0;
            mem_addr_o <= BASE_ADDR;
            mem_wd_o   <= '0;
            mem_we_o   <= 1'b0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                sel_q      <= grant_sel;
                we_q       <= grant_we;
                legal_q    <= grant_legal;
                mem_addr_o <= grant_addr;
                mem_wd_o   <= grant_wd;
                mem_we_o   <= grant_we & grant_legal;
            end else begin
                mem_we_o   <= 1'b0;
            end
        end
    end

    // Per-master read data, updated only at the close of that master's
    // ACCESS cycle and held until its next transaction completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m0_rd_o <= '0;
            m1_rd_o <= '0;
        end else if (state == ST_ACCESS) begin
            if (sel_q) begin
                m1_rd_o <= access_rd;
            end else begin
                m0_rd_o <= access_rd;
            end
        end
    end

    // Ack and error decode from registered state only; the error flag is the
    // inverse of the legality captured at grant time.
    always_comb begin
        m0_ack_o = (state == ST_RESP) && !sel_q;
        m1_ack_o = (state == ST_RESP) &&  sel_q;
        m0_err_o = m0_ack_o && !legal_q;
        m1_err_o = m1_ack_o && !legal_q;
    end

endmodule
